count_monitor: RTL and testbench
================================

// Module: count_monitor
// PURPOSE
//  Downstream consumer of the 4-bit up-counter output. Samples the count each clk, classifies every change
//  (step, wrap, restart, illegal jump), counts wrap-arounds, pulses on a compare match and flags sequence errors.
//  Sits between the counter and status/debug logic; cnt_in is synchronous to clk.
// PARAMETERS
//  WIDTH    4  width of monitored count (max value MAX = 2**WIDTH-1)
//  WRAP_W   8  width of wrap counter (saturating)
// PORTS
//  clk          in   1        rising-edge clock
//  res          in   1        asynchronous, active-low reset
//  cnt_in       in   WIDTH    count value from upstream counter
//  cmp_val      in   WIDTH    compare value for match_pulse (quasi-static)
//  clr          in   1        synchronous clear of wrap_cnt, seq_err, FSM
//  match_pulse  out  1        1-cycle pulse when accepted count changes to cmp_val
//  wrap_pulse   out  1        1-cycle pulse on MAX->0 transition
//  wrap_cnt     out  WRAP_W   number of wraps since reset/clr, saturates at all-ones
//  seq_err      out  1        sticky: illegal jump seen since reset/clr
// BEHAVIOUR
//  - res low: all outputs 0, sample regs s/p = 0, FSM = IDLE; takes effect immediately, mid-operation included.
//  - Pipeline: edge k: s <= cnt_in; edge k+1: outputs from (s, p), p <= s. Latency cnt_in->outputs = 2 cycles.
//  - FSM IDLE: no classification; first cycle after res/clr latches p <= s, -> TRACK. No pulses from IDLE.
//  - FSM TRACK, classify s vs p:
//      s==p                 : hold, no event
//      s==p+1, p!=MAX       : step; no error
//      p==MAX, s==0         : wrap; wrap_pulse=1, wrap_cnt+1 (saturating)
//      s==0, p notin {0,MAX}: restart (upstream reset); legal, no wrap, no error
//      anything else        : illegal; seq_err<=1, -> ERROR
//  - FSM ERROR: p keeps tracking s; match_pulse still active; wrap_pulse and wrap_cnt frozen; exits only via clr/res.
//  - match_pulse: 1 when s!=p and s==cmp_val (edge on change, not level); also in ERROR; never in IDLE.
//  - clr: next edge wrap_cnt=0, seq_err=0, pulses=0, FSM->IDLE. clr wins over a simultaneous wrap/error.
//  - Arithmetic: p+1 computed modulo 2**WIDTH; wrap_cnt saturates (no rollover).
// CONFIGURATION
//  COUNT_MONITOR_GLITCH_FILTER_EN defined: cnt_in is accepted only after holding one value for 2 consecutive
//  samples, which hides ripple-counter transitional codes. Latency becomes 3 cycles. A value lasting 1 cycle
//  is ignored entirely.
//  Undefined: every sample is accepted directly, with 2-cycle latency.
// STRUCTURE
//  Package count_monitor_pkg: typedef enum {IDLE, TRACK, ERROR} cm_state_t; localparam defaults;
//  function cm_classify(s, p) returning a step/wrap/restart/hold/illegal enum.
//  Sub-module count_sample_filter: input sample plus optional glitch filter, selected by the macro.
//  The FSM and counters live in the top.
// TESTING
//  1 res low 2 cycles, then cnt_in 0..15,0 (1 step/cycle) -> one wrap_pulse 2 cycles after 0, wrap_cnt=1, seq_err=0
//  2 cmp_val=9, two full count cycles -> exactly two match_pulses, each 2 cycles after cnt_in==9
//  3 cnt_in 5->9 jump -> seq_err=1 sticky; a following 15->0 gives no wrap_pulse and wrap_cnt unchanged;
//    clr -> seq_err=0, IDLE
//  4 cnt_in 7->0 (upstream reset) -> no seq_err, no wrap_pulse; counting resumes as TRACK
//  5 WRAP_W=2, 5 wraps -> wrap_cnt sticks at 3; clr asserted in the cycle of a wrap -> wrap_cnt=0, no pulse
//  6 res dropped mid-count at cnt_in=12 -> outputs 0 immediately; after release the first sample yields no pulse;
//    with FILTER_EN, a single-cycle 0111->0110->1000 glitch -> no seq_err

Source files
------------

// File: rtl/count_monitor_pkg.sv
// Shared types, default widths and the transition classifier for count_monitor.
package count_monitor_pkg;

   localparam int CM_WIDTH_DEF  = 4;
   localparam int CM_WRAP_W_DEF = 8;

   typedef enum logic [1:0] {IDLE, TRACK, ERROR} cm_state_t;

   typedef enum logic [2:0] {
      CL_HOLD,
      CL_STEP,
      CL_WRAP,
      CL_RESTART,
      CL_ILLEGAL
   } cm_class_t;

   // p < max_val guards the step check, so p+1 never leaves the count range
   function automatic cm_class_t cm_classify(input int unsigned s,
                                             input int unsigned p,
                                             input int unsigned max_val);
      cm_class_t c;
      if (s == p)
         c = CL_HOLD;
      else if ((p != max_val) && (s == p + 1))
         c = CL_STEP;
      else if ((p == max_val) && (s == 0))
         c = CL_WRAP;
      else if (s == 0)
         c = CL_RESTART;
      else
         c = CL_ILLEGAL;
      return c;
   endfunction

endpackage

// File: rtl/count_monitor_if.sv
// Bus between the upstream counter/status logic and count_monitor.
interface count_monitor_if
   import count_monitor_pkg::*;
#(
   parameter int WIDTH  = CM_WIDTH_DEF,
   parameter int WRAP_W = CM_WRAP_W_DEF
);
   logic [WIDTH-1:0]  cnt_in;
   logic [WIDTH-1:0]  cmp_val;
   logic              clr;
   logic              match_pulse;
   logic              wrap_pulse;
   logic [WRAP_W-1:0] wrap_cnt;
   logic              seq_err;

   modport master (
      output cnt_in, cmp_val, clr,
      input  match_pulse, wrap_pulse, wrap_cnt, seq_err
   );

   modport slave (
      input  cnt_in, cmp_val, clr,
      output match_pulse, wrap_pulse, wrap_cnt, seq_err
   );
endinterface

// File: rtl/count_monitor_sample_filter.sv
// Input sample stage of count_monitor; COUNT_MONITOR_GLITCH_FILTER_EN adds a
// two-sample stability filter that hides ripple-counter transitional codes.
module count_sample_filter #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             res,
   input  logic [WIDTH-1:0] i_cnt,
   output logic [WIDTH-1:0] o_s,
   output logic             o_s_vld
);

   logic [WIDTH-1:0] r_s_p0;
   logic             r_vld_p0;

`ifdef COUNT_MONITOR_GLITCH_FILTER_EN
   logic [WIDTH-1:0] r_raw;
   logic             r_raw_vld;

   // a value is accepted only once it has been seen on two consecutive edges
   always_ff @(posedge clk or negedge res) begin
      if (!res) begin
         r_raw     <= '0;
         r_raw_vld <= 1'b0;
         r_s_p0    <= '0;
         r_vld_p0  <= 1'b0;
      end else begin
         r_raw     <= i_cnt;
         r_raw_vld <= 1'b1;
         if (r_raw_vld && (i_cnt == r_raw)) begin
            r_s_p0   <= i_cnt;
            r_vld_p0 <= 1'b1;
         end
      end
   end
`else
   always_ff @(posedge clk or negedge res) begin
      if (!res) begin
         r_s_p0   <= '0;
         r_vld_p0 <= 1'b0;
      end else begin
         r_s_p0   <= i_cnt;
         r_vld_p0 <= 1'b1;
      end
   end
`endif

   assign o_s     = r_s_p0;
   assign o_s_vld = r_vld_p0;

endmodule

// File: rtl/count_monitor.sv
// Monitors an up-counter: classifies changes, counts wraps, flags sequence errors.
// Build option COUNT_MONITOR_GLITCH_FILTER_EN enables the input glitch filter.
module count_monitor
   import count_monitor_pkg::*;
#(
   parameter int WIDTH  = CM_WIDTH_DEF,
   parameter int WRAP_W = CM_WRAP_W_DEF
) (
   input logic            clk,
   input logic            res,
   count_monitor_if.slave bus
);

   localparam int unsigned MAX = (1 << WIDTH) - 1;

   logic [WIDTH-1:0]  w_s_p0;
   logic              w_vld_p0;
   logic [WIDTH-1:0]  r_p_p1;
   cm_state_t         r_state, w_state_nxt;
   cm_class_t         w_class;
   logic              w_chg_match;
   logic              r_match, w_match_nxt;
   logic              r_wrap, w_wrap_nxt;
   logic              r_err, w_err_nxt;
   logic [WRAP_W-1:0] r_wcnt, w_wcnt_nxt;

   function automatic logic [WRAP_W-1:0] sat_inc(input logic [WRAP_W-1:0] v);
      return (&v) ? v : v + 1'b1;
   endfunction

   count_sample_filter #(.WIDTH(WIDTH)) u_sample (
      .clk     (clk),
      .res     (res),
      .i_cnt   (bus.cnt_in),
      .o_s     (w_s_p0),
      .o_s_vld (w_vld_p0)
   );

   // stage p0 -> p1: classify accepted sample against the previous one
   assign w_class     = cm_classify(32'(w_s_p0), 32'(r_p_p1), MAX);
   assign w_chg_match = (w_s_p0 != r_p_p1) && (w_s_p0 == bus.cmp_val);

   always_comb begin
      w_state_nxt = r_state;
      w_match_nxt = 1'b0;
      w_wrap_nxt  = 1'b0;
      w_err_nxt   = r_err;
      w_wcnt_nxt  = r_wcnt;
      if (bus.clr) begin
         w_state_nxt = IDLE;
         w_err_nxt   = 1'b0;
         w_wcnt_nxt  = '0;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_vld_p0)
                  w_state_nxt = TRACK;
            end
            TRACK: begin
               w_match_nxt = w_chg_match;
               case (w_class)
                  CL_WRAP: begin
                     w_wrap_nxt = 1'b1;
                     w_wcnt_nxt = sat_inc(r_wcnt);
                  end
                  CL_ILLEGAL: begin
                     w_err_nxt   = 1'b1;
                     w_state_nxt = ERROR;
                  end
                  default: ;
               endcase
            end
            ERROR: begin
               w_match_nxt = w_chg_match;
            end
            default: w_state_nxt = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge res) begin
      if (!res) begin
         r_state <= IDLE;
         r_p_p1  <= '0;
         r_match <= 1'b0;
         r_wrap  <= 1'b0;
         r_err   <= 1'b0;
         r_wcnt  <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_p_p1  <= w_s_p0;
         r_match <= w_match_nxt;
         r_wrap  <= w_wrap_nxt;
         r_err   <= w_err_nxt;
         r_wcnt  <= w_wcnt_nxt;
      end
   end

   assign bus.match_pulse = r_match;
   assign bus.wrap_pulse  = r_wrap;
   assign bus.wrap_cnt    = r_wcnt;
   assign bus.seq_err     = r_err;

endmodule

// File: tb/tb_count_monitor.sv
// Bench for count_monitor: directed vector table, hand-written reset/glitch
// sequences and randomized traffic against a behavioural model.
`timescale 1ns/1ps
module tb_count_monitor;

`ifdef COUNT_MONITOR_GLITCH_FILTER_EN
   localparam int HOLD = 2;
`else
   localparam int HOLD = 1;
`endif

   logic       clk = 1'b0;
   logic       res = 1'b0;
   logic [3:0] cnt_in = 4'd0;
   logic [3:0] cmp_val = 4'd9;
   logic       clr = 1'b0;

   int checks = 0;
   int errors = 0;

   count_monitor_if #(.WIDTH(4), .WRAP_W(8)) ifa ();
   count_monitor_if #(.WIDTH(4), .WRAP_W(2)) ifb ();

   assign ifa.cnt_in  = cnt_in;
   assign ifa.cmp_val = cmp_val;
   assign ifa.clr     = clr;
   assign ifb.cnt_in  = cnt_in;
   assign ifb.cmp_val = cmp_val;
   assign ifb.clr     = clr;

   count_monitor #(.WIDTH(4), .WRAP_W(8)) dut_a (.clk(clk), .res(res), .bus(ifa.slave));
   count_monitor #(.WIDTH(4), .WRAP_W(2)) dut_b (.clk(clk), .res(res), .bus(ifb.slave));

   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   task automatic check(input string name, input logic [31:0] act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int sat(input int v, input int mx);
      return (v > mx) ? mx : v;
   endfunction

   // behavioural reference: accepted-sample stream and transition rules
   int m_raw, m_s, m_p, m_mode, m_wraps, m_d;
   bit m_raw_v, m_sv, m_match, m_wrap, m_err;

   always @(posedge clk or negedge res) begin
      if (!res) begin
         m_raw = 0; m_raw_v = 0; m_s = 0; m_sv = 0; m_p = 0; m_mode = 0;
         m_wraps = 0; m_match = 0; m_wrap = 0; m_err = 0;
      end else begin
         m_match = 0;
         m_wrap  = 0;
         if (clr) begin
            m_mode = 0; m_wraps = 0; m_err = 0;
         end else if (m_mode == 0) begin
            if (m_sv) m_mode = 1;
         end else begin
            m_d = (m_s - m_p + 16) % 16;
            m_match = (m_d != 0) && (m_s == int'(cmp_val));
            if (m_mode == 1 && m_d != 0) begin
               if (m_d == 1 && m_s == 0) begin
                  m_wrap = 1;
                  m_wraps++;
               end else if (!(m_d == 1 || m_s == 0)) begin
                  m_err  = 1;
                  m_mode = 2;
               end
            end
         end
         m_p = m_s;
`ifdef COUNT_MONITOR_GLITCH_FILTER_EN
         if (m_raw_v && int'(cnt_in) == m_raw) begin
            m_s = int'(cnt_in); m_sv = 1;
         end
         m_raw = int'(cnt_in); m_raw_v = 1;
`else
         m_s = int'(cnt_in); m_sv = 1;
`endif
      end
   end

   bit mdl_en = 1'b0;
   always @(negedge clk) begin
      if (mdl_en) begin
         check("mdl match_a", ifa.match_pulse, m_match);
         check("mdl wrap_a",  ifa.wrap_pulse,  m_wrap);
         check("mdl err_a",   ifa.seq_err,     m_err);
         check("mdl wcnt_a",  ifa.wrap_cnt,    sat(m_wraps, 255));
         check("mdl match_b", ifb.match_pulse, m_match);
         check("mdl wcnt_b",  ifb.wrap_cnt,    sat(m_wraps, 3));
      end
   end

   // one row per accepted value; expectations are the outputs seen after its first edge
   typedef struct {
      int cnt;
      bit clr;
      bit m;
      bit w;
      int wc;
      bit e;
   } vec_t;
   vec_t tbl[$];

   task automatic add(input int c, input bit cl, input bit m, input bit w, input int wc, input bit e);
      vec_t v;
      v.cnt = c; v.clr = cl; v.m = m; v.w = w; v.wc = wc; v.e = e;
      tbl.push_back(v);
   endtask

   task automatic step_hold(input int v);
      cnt_in = 4'(v);
      repeat (HOLD) @(negedge clk);
   endtask

   task automatic check_outputs(input string tag, input bit m, input bit w, input int wc, input bit e);
      check({tag, " match_a"}, ifa.match_pulse, m);
      check({tag, " wrap_a"},  ifa.wrap_pulse,  w);
      check({tag, " wcnt_a"},  ifa.wrap_cnt,    sat(wc, 255));
      check({tag, " err_a"},   ifa.seq_err,     e);
      check({tag, " wrap_b"},  ifb.wrap_pulse,  w);
      check({tag, " wcnt_b"},  ifb.wrap_cnt,    sat(wc, 3));
   endtask

   int cur, r, nh;

   initial begin
      // count up twice with cmp_val=9: two matches, two wraps
      add(0, 0, 0, 0, 0, 0);
      for (int v = 1; v <= 15; v++) add(v, 0, v == 10, 0, 0, 0);
      add(0, 0, 0, 0, 0, 0);
      for (int v = 1; v <= 15; v++) add(v, 0, v == 10, v == 1, 1, 0);
      add(0, 0, 0, 0, 1, 0);
      add(1, 0, 0, 1, 2, 0);
      // upstream restart 7 -> 0
      for (int v = 2; v <= 7; v++) add(v, 0, 0, 0, 2, 0);
      add(0, 0, 0, 0, 2, 0);
      add(1, 0, 0, 0, 2, 0);
      add(2, 0, 0, 0, 2, 0);
      // illegal 5 -> 9, ERROR keeps matching but freezes wraps, then clr
      add(3, 0, 0, 0, 2, 0);
      add(4, 0, 0, 0, 2, 0);
      add(5, 0, 0, 0, 2, 0);
      add(9, 0, 0, 0, 2, 0);
      add(10, 0, 1, 0, 2, 1);
      add(11, 0, 0, 0, 2, 1);
      add(8, 0, 0, 0, 2, 1);
      add(9, 0, 0, 0, 2, 1);
      add(10, 0, 1, 0, 2, 1);
      for (int v = 11; v <= 15; v++) add(v, 0, 0, 0, 2, 1);
      add(0, 0, 0, 0, 2, 1);
      add(1, 0, 0, 0, 2, 1);
      add(2, 1, 0, 0, 0, 0);
      add(3, 0, 0, 0, 0, 0);
      add(4, 0, 0, 0, 0, 0);
      // five wraps: 8-bit counter shows 5, 2-bit counter saturates at 3
      for (int k = 1; k <= 5; k++) begin
         for (int v = (k == 1) ? 5 : 2; v <= 15; v++) add(v, 0, v == 10, 0, k - 1, 0);
         add(0, 0, 0, 0, k - 1, 0);
         add(1, 0, 0, 1, k, 0);
      end
      // clr in the same cycle as a wrap
      for (int v = 2; v <= 15; v++) add(v, 0, v == 10, 0, 5, 0);
      add(0, 0, 0, 0, 5, 0);
      add(1, 1, 0, 0, 0, 0);
      add(2, 0, 0, 0, 0, 0);
      add(3, 0, 0, 0, 0, 0);

      mdl_en = 1'b1;
      @(negedge clk);
      @(negedge clk);
      check_outputs("reset", 0, 0, 0, 0);
      res = 1'b1;

      for (int i = 0; i < tbl.size(); i++) begin
         cnt_in = 4'(tbl[i].cnt);
         clr    = tbl[i].clr;
         @(negedge clk);
         check_outputs($sformatf("tbl[%0d]", i), tbl[i].m, tbl[i].w, tbl[i].wc, tbl[i].e);
         for (int h = 1; h < HOLD; h++) @(negedge clk);
      end
      clr = 1'b0;

      // reset dropped mid-count at 12 clears outputs without a clock edge
      for (int v = 4; v <= 15; v++) step_hold(v);
      for (int v = 0; v <= 12; v++) step_hold(v);
      @(negedge clk);
      check("pre-reset wcnt_a", ifa.wrap_cnt, 1);
      #2 res = 1'b0;
      #1 check_outputs("async reset", 0, 0, 0, 0);
      @(negedge clk);
      cmp_val = 4'd12;
      cnt_in  = 4'd12;
      res     = 1'b1;
      for (int c = 0; c < 3 * HOLD; c++) begin
         if (c == HOLD) cnt_in = 4'd13;
         if (c == 2 * HOLD) cnt_in = 4'd14;
         @(negedge clk);
         check("post-reset match_a", ifa.match_pulse, 0);
      end
      cmp_val = 4'd9;

`ifdef COUNT_MONITOR_GLITCH_FILTER_EN
      // single-cycle ripple code 0110 between 0111 and 1000 is filtered out
      step_hold(15); step_hold(0); step_hold(1);
      step_hold(2); step_hold(3); step_hold(4); step_hold(5); step_hold(6); step_hold(7);
      cnt_in = 4'd6;
      @(negedge clk);
      step_hold(8); step_hold(9); step_hold(10);
      repeat (2) @(negedge clk);
      check("glitch err_a", ifa.seq_err, 0);
`endif

      // randomized traffic against the model
      cur = 0;
      repeat (700) begin
         r = $urandom_range(0, 99);
         if (r < 70)      cur = (cur + 1) % 16;
         else if (r < 80) cur = cur;
         else if (r < 86) cur = 0;
         else             cur = $urandom_range(0, 15);
         clr = ($urandom_range(0, 59) == 0);
         if ($urandom_range(0, 149) == 0) cmp_val = 4'($urandom_range(0, 15));
         cnt_in = 4'(cur);
         nh = $urandom_range(1, HOLD + 1);
         repeat (nh) @(negedge clk);
         if ($urandom_range(0, 199) == 0) begin
            #3 res = 1'b0;
            #4 res = 1'b1;
            @(negedge clk);
         end
      end
      clr = 1'b0;
      repeat (4) @(negedge clk);
      mdl_en = 1'b0;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
